// File: rtl/lsb_queue.sv
// lsb_queue: in-order load/store queue between dispatch, the CDB, the ROB and
// the memory controller. Holds up to DEPTH memory ops in program order,
// snoops the ALU broadcast and its own load broadcast for operands, executes
// loads at the head, announces resolved stores to the ROB, and writes
// committed stores to memory. Committed stores survive a flush.
//
// Ports:
//   clk_in, rst_in, rdy_in            clock, sync active-high reset, global enable
//   issue_*                           dispatch of one op (legal when !full_out)
//   full_out, count_out               occupancy
//   cdb0_*                            ALU result broadcast (snooped)
//   ld_bc_*                           load result broadcast (also snooped here)
//   st_rdy_*                          store resolved, ROB may commit it
//   commit_*                          ROB commits the store with this tag
//   flush_in                          mispredict rollback
//   mem_req_*, mem_done, mem_rdata    memory controller handshake
//
// Memory FSM states:
//   state   | meaning
//   M_IDLE  | no request outstanding
//   M_LOAD  | head load request outstanding, result will be broadcast
//   M_STORE | head committed-store request outstanding
//   M_DRAIN | flushed load outstanding, result will be dropped
//
// Entry states:
//   E_WAIT  | waiting on qj/qk producer
//   E_RDY   | operands captured
//   E_ANN   | store announced to the ROB
//   E_COMM  | store committed, survives flush
//   E_INFL  | load issued to memory
module lsb_queue #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       issue_valid,
  input  logic                       issue_is_store,
  input  logic [2:0]                 issue_funct3,
  input  logic [TAG_W-1:0]           issue_tag,
  input  logic [TAG_W-1:0]           issue_qj,
  input  logic [TAG_W-1:0]           issue_qk,
  input  logic [31:0]                issue_vj,
  input  logic [31:0]                issue_vk,
  input  logic [31:0]                issue_imm,
  output logic                       full_out,
  output logic [$clog2(DEPTH):0]     count_out,
  input  logic                       cdb0_valid,
  input  logic [TAG_W-1:0]           cdb0_tag,
  input  logic [31:0]                cdb0_value,
  output logic                       ld_bc_valid,
  output logic [TAG_W-1:0]           ld_bc_tag,
  output logic [31:0]                ld_bc_value,
  output logic                       st_rdy_valid,
  output logic [TAG_W-1:0]           st_rdy_tag,
  input  logic                       commit_valid,
  input  logic [TAG_W-1:0]           commit_tag,
  input  logic                       flush_in,
  output logic                       mem_req_valid,
  output logic                       mem_req_we,
  output logic [ADDR_W-1:0]          mem_req_addr,
  output logic [31:0]                mem_req_wdata,
  output logic [2:0]                 mem_req_funct3,
  input  logic                       mem_done,
  input  logic [31:0]                mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {E_WAIT, E_RDY, E_ANN, E_COMM, E_INFL} est_t;
  typedef enum logic [1:0] {M_IDLE, M_LOAD, M_STORE, M_DRAIN} mst_t;

  typedef struct packed {
    logic             valid;
    logic             is_store;
    logic [2:0]       funct3;
    logic [TAG_W-1:0] tag;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic [31:0]      imm;
    est_t             st;
  } ent_t;

  ent_t          ent_q [DEPTH];
  ent_t          ent_d [DEPTH];
  ent_t          new_ent;
  ent_t          head_ent;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, ncommit_q, ncommit_d;
  mst_t          mst_q;

  logic          launch_ld, launch_st, pop, pop_st, issue_ok, commit_hit;
  logic          ann_found;
  logic [PW-1:0] ann_idx, scan_idx;
  logic [31:0]   ea;

  assign count_out = count_q;
  assign full_out  = (count_q == CW'(DEPTH));
  assign head_ent  = ent_q[head_q];
  assign ea        = head_ent.vj + head_ent.imm;
  assign issue_ok  = issue_valid && !full_out && !flush_in;

  // A load about to be flushed is not started; a committed store always is.
  assign launch_ld = (mst_q == M_IDLE) && head_ent.valid && !head_ent.is_store &&
                     (head_ent.st == E_RDY) && !flush_in;
  assign launch_st = (mst_q == M_IDLE) && head_ent.valid && head_ent.is_store &&
                     (head_ent.st == E_COMM);
  assign pop_st    = mem_done && (mst_q == M_STORE);
  assign pop       = pop_st || (mem_done && (mst_q == M_LOAD) && !flush_in);

  // Oldest resolved store wins the single st_rdy slot.
  always_comb begin
    ann_found = 1'b0;
    ann_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PW'(i);
      if (!ann_found && ent_q[scan_idx].valid && ent_q[scan_idx].is_store &&
          (ent_q[scan_idx].st == E_RDY)) begin
        ann_found = 1'b1;
        ann_idx   = scan_idx;
      end
    end
  end

  // New entry with same-cycle broadcast bypass on both operands.
  always_comb begin
    new_ent          = '0;
    new_ent.valid    = 1'b1;
    new_ent.is_store = issue_is_store;
    new_ent.funct3   = issue_funct3;
    new_ent.tag      = issue_tag;
    new_ent.qj       = issue_qj;
    new_ent.qk       = issue_qk;
    new_ent.vj       = issue_vj;
    new_ent.vk       = issue_vk;
    new_ent.imm      = issue_imm;
    if (issue_qj != '0) begin
      if (cdb0_valid && issue_qj == cdb0_tag) begin
        new_ent.vj = cdb0_value;
        new_ent.qj = '0;
      end else if (ld_bc_valid && issue_qj == ld_bc_tag) begin
        new_ent.vj = ld_bc_value;
        new_ent.qj = '0;
      end
    end
    if (issue_qk != '0) begin
      if (cdb0_valid && issue_qk == cdb0_tag) begin
        new_ent.vk = cdb0_value;
        new_ent.qk = '0;
      end else if (ld_bc_valid && issue_qk == ld_bc_tag) begin
        new_ent.vk = ld_bc_value;
        new_ent.qk = '0;
      end
    end
    new_ent.st = (new_ent.qj == '0 && new_ent.qk == '0) ? E_RDY : E_WAIT;
  end

  always_comb begin
    commit_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].valid) begin
        if (ent_q[i].qj != '0) begin
          if (cdb0_valid && ent_q[i].qj == cdb0_tag) begin
            ent_d[i].vj = cdb0_value;
            ent_d[i].qj = '0;
          end else if (ld_bc_valid && ent_q[i].qj == ld_bc_tag) begin
            ent_d[i].vj = ld_bc_value;
            ent_d[i].qj = '0;
          end
        end
        if (ent_q[i].qk != '0) begin
          if (cdb0_valid && ent_q[i].qk == cdb0_tag) begin
            ent_d[i].vk = cdb0_value;
            ent_d[i].qk = '0;
          end else if (ld_bc_valid && ent_q[i].qk == ld_bc_tag) begin
            ent_d[i].vk = ld_bc_value;
            ent_d[i].qk = '0;
          end
        end
        if (ent_q[i].st == E_WAIT && ent_d[i].qj == '0 && ent_d[i].qk == '0)
          ent_d[i].st = E_RDY;
        if (commit_valid && ent_q[i].is_store && ent_q[i].st == E_ANN &&
            ent_q[i].tag == commit_tag) begin
          ent_d[i].st = E_COMM;
          commit_hit  = 1'b1;
        end
      end
    end
    if (ann_found && !flush_in) ent_d[ann_idx].st = E_ANN;
    if (launch_ld) ent_d[head_q].st = E_INFL;
    if (pop) ent_d[head_q].valid = 1'b0;

    ncommit_d = ncommit_q + CW'(commit_hit) - CW'(pop_st);
    head_d    = head_q + PW'(pop);

    // Committed stores form a prefix from head, so they survive as the new queue.
    if (flush_in) begin
      for (int i = 0; i < DEPTH; i++)
        if (ent_d[i].st != E_COMM) ent_d[i].valid = 1'b0;
      count_d = ncommit_d;
      tail_d  = head_d + ncommit_d[PW-1:0];
    end else begin
      count_d = count_q + CW'(issue_ok) - CW'(pop);
      tail_d  = tail_q + PW'(issue_ok);
      if (issue_ok) ent_d[tail_q] = new_ent;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      ncommit_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else if (rdy_in) begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      ncommit_q <= ncommit_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mst_q          <= M_IDLE;
      mem_req_valid  <= 1'b0;
      mem_req_we     <= 1'b0;
      mem_req_addr   <= '0;
      mem_req_wdata  <= '0;
      mem_req_funct3 <= '0;
      ld_bc_valid    <= 1'b0;
      ld_bc_tag      <= '0;
      ld_bc_value    <= '0;
      st_rdy_valid   <= 1'b0;
      st_rdy_tag     <= '0;
    end else if (rdy_in) begin
      st_rdy_valid <= ann_found && !flush_in;
      st_rdy_tag   <= (ann_found && !flush_in) ? ent_q[ann_idx].tag : '0;
      ld_bc_valid  <= 1'b0;
      case (mst_q)
        M_IDLE: begin
          if (launch_ld || launch_st) begin
            mst_q          <= launch_ld ? M_LOAD : M_STORE;
            mem_req_valid  <= 1'b1;
            mem_req_we     <= launch_st;
            mem_req_addr   <= ADDR_W'(ea);
            mem_req_wdata  <= launch_st ? head_ent.vk : 32'h0;
            mem_req_funct3 <= head_ent.funct3;
          end
        end
        M_LOAD: begin
          if (mem_done) begin
            mst_q          <= M_IDLE;
            mem_req_valid  <= 1'b0;
            mem_req_we     <= 1'b0;
            mem_req_addr   <= '0;
            mem_req_wdata  <= '0;
            mem_req_funct3 <= '0;
            if (!flush_in) begin
              ld_bc_valid <= 1'b1;
              ld_bc_tag   <= head_ent.tag;
              ld_bc_value <= mem_rdata;
            end
          end else if (flush_in) begin
            mst_q <= M_DRAIN;
          end
        end
        M_STORE, M_DRAIN: begin
          if (mem_done) begin
            mst_q          <= M_IDLE;
            mem_req_valid  <= 1'b0;
            mem_req_we     <= 1'b0;
            mem_req_addr   <= '0;
            mem_req_wdata  <= '0;
            mem_req_funct3 <= '0;
          end
        end
        default: mst_q <= M_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsb_queue.sv
module tb_lsb_queue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int AW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk_in = 1'b0;
  logic             rst_in, rdy_in;
  logic             issue_valid, issue_is_store;
  logic [2:0]       issue_funct3;
  logic [TAG_W-1:0] issue_tag, issue_qj, issue_qk;
  logic [31:0]      issue_vj, issue_vk, issue_imm;
  logic             full_out;
  logic [CW-1:0]    count_out;
  logic             cdb0_valid;
  logic [TAG_W-1:0] cdb0_tag;
  logic [31:0]      cdb0_value;
  logic             ld_bc_valid;
  logic [TAG_W-1:0] ld_bc_tag;
  logic [31:0]      ld_bc_value;
  logic             st_rdy_valid;
  logic [TAG_W-1:0] st_rdy_tag;
  logic             commit_valid;
  logic [TAG_W-1:0] commit_tag;
  logic             flush_in;
  logic             mem_req_valid, mem_req_we;
  logic [AW-1:0]    mem_req_addr;
  logic [31:0]      mem_req_wdata;
  logic [2:0]       mem_req_funct3;
  logic             mem_done;
  logic [31:0]      mem_rdata;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk_in = ~clk_in;

  lsb_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ADDR_W(AW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_is_store(issue_is_store),
    .issue_funct3(issue_funct3), .issue_tag(issue_tag),
    .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_imm(issue_imm),
    .full_out(full_out), .count_out(count_out),
    .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_value(cdb0_value),
    .ld_bc_valid(ld_bc_valid), .ld_bc_tag(ld_bc_tag), .ld_bc_value(ld_bc_value),
    .st_rdy_valid(st_rdy_valid), .st_rdy_tag(st_rdy_tag),
    .commit_valid(commit_valid), .commit_tag(commit_tag),
    .flush_in(flush_in),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_req_funct3(mem_req_funct3),
    .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change at negedge; outputs are checked at negedge after the edge.
  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic set_issue(input logic st, input logic [2:0] f3, input logic [3:0] tag,
                           input logic [3:0] qj, input logic [3:0] qk,
                           input logic [31:0] vj, input logic [31:0] vk,
                           input logic [31:0] imm);
    issue_valid    = 1'b1;
    issue_is_store = st;
    issue_funct3   = f3;
    issue_tag      = tag;
    issue_qj       = qj;
    issue_qk       = qk;
    issue_vj       = vj;
    issue_vk       = vk;
    issue_imm      = imm;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1;
    issue_valid = 1'b0; issue_is_store = 1'b0; issue_funct3 = '0; issue_tag = '0;
    issue_qj = '0; issue_qk = '0; issue_vj = '0; issue_vk = '0; issue_imm = '0;
    cdb0_valid = 1'b0; cdb0_tag = '0; cdb0_value = '0;
    commit_valid = 1'b0; commit_tag = '0; flush_in = 1'b0;
    mem_done = 1'b0; mem_rdata = '0;
    @(negedge clk_in);
    tick(); tick();
    rst_in = 1'b0;

    // Reset state
    chk("rst_count", 64'(count_out), 64'd0);
    chk("rst_full", 64'(full_out), 64'd0);
    chk("rst_memreq", 64'(mem_req_valid), 64'd0);
    chk("rst_ldbc", 64'(ld_bc_valid), 64'd0);
    chk("rst_strdy", 64'(st_rdy_valid), 64'd0);
    chk("rst_addr", 64'(mem_req_addr), 64'd0);

    // Fill with loads waiting on tag 7
    for (int i = 0; i < DEPTH; i++) begin
      set_issue(1'b0, 3'd2, 4'(i + 1), 4'd7, 4'd0, 32'h0, 32'h0, 32'h0);
      tick();
      chk("fill_count", 64'(count_out), 64'(i + 1));
      chk("fill_full", 64'(full_out), (i == DEPTH - 1) ? 64'd1 : 64'd0);
    end
    set_issue(1'b0, 3'd2, 4'd9, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0);
    tick();
    issue_valid = 1'b0;
    chk("issue_when_full", 64'(count_out), 64'(DEPTH));
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    chk("flush_empty_count", 64'(count_out), 64'd0);
    chk("flush_empty_full", 64'(full_out), 64'd0);
    chk("flush_no_req", 64'(mem_req_valid), 64'd0);

    // Ready load: 0x100 + (-4)
    set_issue(1'b0, 3'd2, 4'd1, 4'd0, 4'd0, 32'h100, 32'h0, 32'hFFFF_FFFC);
    tick();
    issue_valid = 1'b0;
    chk("ld_req_t1", 64'(mem_req_valid), 64'd0);
    tick();
    chk("ld_req_t2", 64'(mem_req_valid), 64'd1);
    chk("ld_addr", 64'(mem_req_addr), 64'h0FC);
    chk("ld_we", 64'(mem_req_we), 64'd0);
    chk("ld_f3", 64'(mem_req_funct3), 64'd2);
    tick();
    chk("ld_hold", 64'(mem_req_addr), 64'h0FC);
    mem_done = 1'b1; mem_rdata = 32'h55;
    tick();
    mem_done = 1'b0;
    chk("ld_bc_valid", 64'(ld_bc_valid), 64'd1);
    chk("ld_bc_tag", 64'(ld_bc_tag), 64'd1);
    chk("ld_bc_value", 64'(ld_bc_value), 64'h55);
    chk("ld_pop_count", 64'(count_out), 64'd0);
    chk("ld_req_drop", 64'(mem_req_valid), 64'd0);
    tick();
    chk("ld_bc_one_cycle", 64'(ld_bc_valid), 64'd0);

    // Issue-cycle bypass from cdb0
    set_issue(1'b0, 3'd0, 4'd2, 4'd3, 4'd0, 32'hDEAD, 32'h0, 32'h10);
    cdb0_valid = 1'b1; cdb0_tag = 4'd3; cdb0_value = 32'h2000;
    tick();
    issue_valid = 1'b0; cdb0_valid = 1'b0;
    chk("byp_req_t1", 64'(mem_req_valid), 64'd0);
    tick();
    chk("byp_req_t2", 64'(mem_req_valid), 64'd1);
    chk("byp_addr", 64'(mem_req_addr), 64'h2010);
    mem_done = 1'b1; mem_rdata = 32'h77;
    tick();
    mem_done = 1'b0;
    chk("byp_bc_tag", 64'(ld_bc_tag), 64'd2);
    chk("byp_bc_value", 64'(ld_bc_value), 64'h77);
    tick();

    // Store tag 5: announce, ignore wrong commit, commit, write
    set_issue(1'b1, 3'd0, 4'd5, 4'd0, 4'd0, 32'h40, 32'hCAFE_BABE, 32'h8);
    tick();
    issue_valid = 1'b0;
    chk("st_rdy_early", 64'(st_rdy_valid), 64'd0);
    tick();
    chk("st_rdy_valid", 64'(st_rdy_valid), 64'd1);
    chk("st_rdy_tag", 64'(st_rdy_tag), 64'd5);
    commit_valid = 1'b1; commit_tag = 4'd9;
    tick();
    commit_valid = 1'b0;
    chk("st_rdy_once", 64'(st_rdy_valid), 64'd0);
    tick();
    chk("st_wrong_commit", 64'(mem_req_valid), 64'd0);
    commit_valid = 1'b1; commit_tag = 4'd5;
    tick();
    commit_valid = 1'b0;
    tick();
    chk("st_req", 64'(mem_req_valid), 64'd1);
    chk("st_we", 64'(mem_req_we), 64'd1);
    chk("st_addr", 64'(mem_req_addr), 64'h48);
    chk("st_wdata", 64'(mem_req_wdata), 64'hCAFE_BABE);
    chk("st_count", 64'(count_out), 64'd1);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("st_pop_count", 64'(count_out), 64'd0);
    chk("st_req_drop", 64'(mem_req_valid), 64'd0);
    chk("st_no_bc", 64'(ld_bc_valid), 64'd0);

    // Committed store at head, two younger loads, flush (pointers wrap here)
    set_issue(1'b1, 3'd1, 4'd2, 4'd0, 4'd0, 32'h200, 32'h11, 32'h0);
    tick();
    set_issue(1'b0, 3'd2, 4'd6, 4'd0, 4'd0, 32'h300, 32'h0, 32'h0);
    tick();
    chk("fl_strdy_tag", 64'(st_rdy_tag), 64'd2);
    set_issue(1'b0, 3'd2, 4'd7, 4'd0, 4'd0, 32'h304, 32'h0, 32'h0);
    commit_valid = 1'b1; commit_tag = 4'd2;
    tick();
    issue_valid = 1'b0; commit_valid = 1'b0;
    chk("fl_count3", 64'(count_out), 64'd3);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    chk("fl_count1", 64'(count_out), 64'd1);
    chk("fl_st_req", 64'(mem_req_valid), 64'd1);
    chk("fl_st_we", 64'(mem_req_we), 64'd1);
    chk("fl_st_addr", 64'(mem_req_addr), 64'h200);
    chk("fl_st_wdata", 64'(mem_req_wdata), 64'h11);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("fl_st_pop", 64'(count_out), 64'd0);
    tick(); tick(); tick();
    chk("fl_no_load_req", 64'(mem_req_valid), 64'd0);
    chk("fl_no_bc", 64'(ld_bc_valid), 64'd0);

    // In-flight load, flush, then a late completion is dropped
    set_issue(1'b0, 3'd2, 4'd8, 4'd0, 4'd0, 32'h500, 32'h0, 32'h0);
    tick();
    issue_valid = 1'b0;
    tick();
    chk("dr_req", 64'(mem_req_valid), 64'd1);
    chk("dr_addr", 64'(mem_req_addr), 64'h500);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    chk("dr_count", 64'(count_out), 64'd0);
    chk("dr_req_held", 64'(mem_req_valid), 64'd1);
    mem_done = 1'b1; mem_rdata = 32'h99;
    tick();
    mem_done = 1'b0;
    chk("dr_no_bc", 64'(ld_bc_valid), 64'd0);
    chk("dr_req_drop", 64'(mem_req_valid), 64'd0);

    // Global enable low: issue ignored
    rdy_in = 1'b0;
    set_issue(1'b0, 3'd2, 4'd9, 4'd0, 4'd0, 32'h600, 32'h0, 32'h0);
    tick();
    chk("frz_count", 64'(count_out), 64'd0);
    rdy_in = 1'b1;
    tick();
    issue_valid = 1'b0;
    chk("post_count", 64'(count_out), 64'd1);
    tick();
    chk("post_req", 64'(mem_req_valid), 64'd1);
    chk("post_addr", 64'(mem_req_addr), 64'h600);
    mem_done = 1'b1; mem_rdata = 32'hAB;
    tick();
    mem_done = 1'b0;
    chk("post_bc_valid", 64'(ld_bc_valid), 64'd1);
    chk("post_bc_tag", 64'(ld_bc_tag), 64'd9);
    chk("post_bc_value", 64'(ld_bc_value), 64'hAB);
    chk("post_count0", 64'(count_out), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lsb_queue.md
# lsb_queue

Parametrised in-order load/store queue between the dispatcher, the reservation-station CDB, the ROB and the memory controller. It buffers up to DEPTH memory ops in program order and snoops two result broadcast ports for operands. Loads execute at the head; stores report readiness to the ROB out of order and write memory after commit. On a mispredict flush, stores already committed survive and still drain to memory, and an in-flight load is completed and discarded.

## Interface
- DEPTH, 16: entry count, power of two, ≥2.
- TAG_W, 4: ROB tag width; tag 0 = operand ready (null).
- ADDR_W, 32: memory address width.
- clk_in  in  1  system clock.
- rst_in  in  1  synchronous, active-high reset.
- rdy_in  in  1  global enable; low = hold every register, ignore all inputs.
- issue_valid  in  1  dispatch one op this cycle; legal only when full_out=0.
- issue_is_store  in  1  1 = store, 0 = load.
- issue_funct3  in  3  size/sign code, passed to memory unchanged.
- issue_tag  in  TAG_W  ROB tag of the op.
- issue_qj / issue_qk  in  TAG_W  producer tags of base / store data (0 = ready).
- issue_vj / issue_vk  in  32  base / store data values.
- issue_imm  in  32  sign-extended offset.
- full_out  out  1  count == DEPTH.
- count_out  out  $clog2(DEPTH)+1  occupancy.
- cdb0_valid, cdb0_tag, cdb0_value  in  1/TAG_W/32  ALU broadcast.
- ld_bc_valid, ld_bc_tag, ld_bc_value  out  1/TAG_W/32  load result broadcast; also snooped internally as second CDB.
- st_rdy_valid, st_rdy_tag  out  1/TAG_W  store address+data resolved, ROB may commit it.
- commit_valid, commit_tag  in  1/TAG_W  ROB commits the store with this tag.
- flush_in  in  1  mispredict rollback.
- mem_req_valid, mem_req_we  out  1/1  memory request, held until mem_done.
- mem_req_addr  out  ADDR_W  low ADDR_W bits of vj+imm (32-bit wrap).
- mem_req_wdata  out  32  store data.
- mem_req_funct3  out  3  from entry.
- mem_done  in  1  single-cycle completion pulse.
- mem_rdata  in  32  load data, valid with mem_done.

## Operation
- Storage: circular buffer, head/tail pointers mod DEPTH plus count register; full and empty distinguished by count, so all DEPTH slots are usable. Also a committed-store counter ncommit.
- Entry state: WAIT (operand pending), RDY, ANNOUNCED (store, st_rdy sent), COMMITTED (store), INFLIGHT.
- Wakeup: every valid entry compares qj/qk against cdb0 and ld_bc tags each cycle; on match capture value, clear Q. Issue-cycle bypass: if issue_qj/qk matches a broadcast valid in the same cycle, the entry is written with value and Q=0.
- Operand ready: WAIT → RDY the cycle after both Q are 0.
- Store announce: among RDY stores, the one nearest head emits st_rdy (one per cycle, registered) → ANNOUNCED.
- Commit: commit_tag matching an ANNOUNCED store → COMMITTED, ncommit+1. Non-matching tag ignored.
- Memory FSM: IDLE, LOAD, STORE, DRAIN. From IDLE: head RDY load → LOAD; head COMMITTED store → STORE; request registered next cycle. LOAD + mem_done → ld_bc pulse, pop head, IDLE. STORE + mem_done → pop head, ncommit−1, IDLE. DRAIN + mem_done → drop data, no broadcast, IDLE.
- Flush: all non-committed entries invalidated; tail = head + ncommit; count = ncommit; ld_bc and st_rdy forced 0. LOAD in flight → DRAIN; STORE in flight continues. Issue in the flush cycle is ignored; commit in the flush cycle is applied first.
- Simultaneous issue and pop: count unchanged; issue when full is a protocol error (ignored).
- Reset: pointers, count, ncommit 0; all entries invalid; FSM IDLE; every output 0 (full_out 0, count_out 0).

## Timing
- Issue at t with ready operands: load request at t+2 earliest (RDY at t+1, request registered at t+2).
- mem_done at d: ld_bc_valid at d+1 for exactly one cycle; head pop and count update visible at d+1; next head request at d+2 earliest.
- Store: st_rdy one cycle after RDY; memory request the cycle after COMMITTED reaches head with FSM IDLE.
- mem_req_* stable from assertion until the mem_done cycle; deassert at d+1 unless back-to-back.
- rdy_in low: full freeze, including a pending mem_done (the controller is frozen too).

## Test plan
- Reset then idle: all outputs 0; issue DEPTH ops → full_out=1 and count_out=DEPTH exactly at the DEPTH-th op.
- Load vj=0x100, imm=−4, qj=0 → mem_req addr 0xFC, we=0 at t+2; mem_done rdata=0x55 → ld_bc tag/value 0x55 one cycle later, count−1.
- Load with qj=3; cdb0 tag3 value 0x2000 on the issue cycle → bypass, request addr 0x2000+imm with no extra delay.
- Store tag5 ready → st_rdy tag5; commit tag5 → we=1 request with wdata; mem_done → pop.
- Committed store tag2 at head + 2 younger loads, flush → count=1, store still written, loads never requested.
- Load in flight, flush, then mem_done → no ld_bc pulse; FSM IDLE; a new issue proceeds; pointers wrap past DEPTH−1 correctly.
